// File: rtl/rbm_pkg.sv
// Shared types for the RBM group scheduler: FSM state encoding and counter-width helper.
package rbm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        WAIT,
        FINISH
    } state_t;

    // Bits needed for a counter that must be able to hold the value n itself.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rbm_free_picker.sv
// Chooses which free groups receive an index this cycle (lowest group first) and each
// chosen group's offset from the shared next-index counter.
module rbm_free_picker #(
    parameter int unsigned GROUP_NUM = 4,
    parameter int unsigned CW        = 9
) (
    input  logic [GROUP_NUM-1:0]         free_mask,
    input  logic [CW-1:0]                remaining,
    output logic [GROUP_NUM-1:0]         pick_mask,
    output logic [GROUP_NUM-1:0][CW-1:0] pick_off,
    output logic [CW-1:0]                pick_cnt
);

    always_comb begin
        pick_mask = '0;
        pick_off  = '0;
        pick_cnt  = '0;
        for (int unsigned g = 0; g < GROUP_NUM; g++) begin
            if (free_mask[g] && (pick_cnt < remaining)) begin
                pick_mask[g] = 1'b1;
                pick_off[g]  = pick_cnt;
                pick_cnt     = pick_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rbm_group_scheduler.sv
// Dispatches neuron indices of one RBM layer pass across shared adder groups and collects
// the sampled bits. Optional watchdog enabled by defining RBM_SCHED_TIMEOUT_EN.
module rbm_group_scheduler
    import rbm_pkg::*;
#(
    parameter int unsigned NEURON_NUM = 441,
    parameter int unsigned GROUP_NUM  = 4,
    parameter int unsigned IDX_W      = 9,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [GROUP_NUM-1:0]         grp_done,
    input  logic [GROUP_NUM-1:0]         grp_bit,
    output logic [GROUP_NUM-1:0]         grp_start,
    output logic [GROUP_NUM*IDX_W-1:0]   grp_idx,
    output logic [NEURON_NUM-1:0]        hidden_data,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int unsigned   CW   = idx_bits(NEURON_NUM);
    localparam logic [CW-1:0] LAST = CW'(NEURON_NUM);

    state_t                        state_q, state_d;
    logic [CW-1:0]                 next_idx_q;
    logic [GROUP_NUM-1:0]          busy_q;
    logic [GROUP_NUM-1:0][IDX_W-1:0] idx_q;
    logic [NEURON_NUM-1:0]         hidden_q;
    logic                          err_q;

    logic [GROUP_NUM-1:0]          free_mask, pick_mask, done_hit, done_stray;
    logic [GROUP_NUM-1:0][CW-1:0]  pick_off;
    logic [CW-1:0]                 remaining, pick_cnt, idx_after;
    logic                          accept, wd_expire;

    rbm_free_picker #(
        .GROUP_NUM (GROUP_NUM),
        .CW        (CW)
    ) u_picker (
        .free_mask (free_mask),
        .remaining (remaining),
        .pick_mask (pick_mask),
        .pick_off  (pick_off),
        .pick_cnt  (pick_cnt)
    );

    always_comb begin
        accept     = (state_q == IDLE) && start;
        free_mask  = (state_q == DISPATCH) ? ~busy_q : '0;
        remaining  = LAST - next_idx_q;
        idx_after  = next_idx_q + pick_cnt;
        done_hit   = grp_done & busy_q;
        done_stray = grp_done & ~busy_q;

        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = DISPATCH;
            DISPATCH: if (idx_after == LAST) state_d = WAIT;
            WAIT:     if (busy_q == '0) state_d = FINISH;
            FINISH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (wd_expire) state_d = IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            next_idx_q <= '0;
            busy_q     <= '0;
            idx_q      <= '0;
            hidden_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((|done_stray) || wd_expire) err_q <= 1'b1;
            if (accept) begin
                next_idx_q <= '0;
                busy_q     <= '0;
                hidden_q   <= '0;
            end else begin
                next_idx_q <= idx_after;
                // A freed group only shows up in free_mask next cycle, so it is never re-picked
                // on the same edge that captured its result.
                busy_q <= wd_expire ? '0 : ((busy_q & ~grp_done) | pick_mask);
                for (int unsigned g = 0; g < GROUP_NUM; g++) begin
                    if (done_hit[g]) hidden_q[idx_q[g]] <= grp_bit[g];
                end
            end
            for (int unsigned g = 0; g < GROUP_NUM; g++) begin
                if (pick_mask[g]) idx_q[g] <= IDX_W'(next_idx_q + pick_off[g]);
            end
        end
    end

`ifdef RBM_SCHED_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wd_cnt_q;
    logic          wd_clear;

    assign wd_clear  = (|grp_done) || (|pick_mask);
    assign wd_expire = (|busy_q) && !wd_clear && (wd_cnt_q == WW'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt_q <= '0;
        end else if (wd_clear || wd_expire) begin
            wd_cnt_q <= '0;
        end else if (|busy_q) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    for (genvar g = 0; g < GROUP_NUM; g++) begin : g_idx_out
        assign grp_idx[g*IDX_W +: IDX_W] = pick_mask[g] ? IDX_W'(next_idx_q + pick_off[g]) : idx_q[g];
    end

    assign grp_start   = pick_mask;
    assign hidden_data = hidden_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FINISH) || wd_expire;
    assign err         = err_q;

endmodule

// File: tb/tb_rbm_group_scheduler.sv
// Directed bench for rbm_group_scheduler with 10 neurons over 4 groups; groups answer
// 3 cycles after grp_start with grp_bit = idx[0].
module tb_rbm_group_scheduler;

    logic        clock;
    logic        reset;
    logic        start;
    logic [3:0]  grp_done;
    logic [3:0]  grp_bit;
    logic [3:0]  grp_start;
    logic [15:0] grp_idx;
    logic [9:0]  hidden_data;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic       drv_start = 1'b0;
    logic [3:0] inj_done  = '0;
    logic [3:0] inj_bit   = '0;
    logic [3:0] resp_en   = 4'b1111;
    logic [3:0] pend      = '0;
    int         cnt  [4];
    logic [3:0] pidx [4];

    rbm_group_scheduler #(
        .NEURON_NUM (10),
        .GROUP_NUM  (4),
        .IDX_W      (4),
        .TIMEOUT    (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .grp_done    (grp_done),
        .grp_bit     (grp_bit),
        .grp_start   (grp_start),
        .grp_idx     (grp_idx),
        .hidden_data (hidden_data),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One cycle: sample at the falling edge, run the group responders, drive next inputs.
    task automatic step();
        logic [3:0] dv, bv;
        @(negedge clock);
        dv = '0;
        bv = '0;
        for (int g = 0; g < 4; g++) begin
            if (pend[g]) begin
                if (cnt[g] == 1) begin
                    dv[g]   = resp_en[g];
                    bv[g]   = pidx[g][0];
                    pend[g] = 1'b0;
                end else begin
                    cnt[g] = cnt[g] - 1;
                end
            end
            if (grp_start[g]) begin
                pend[g] = 1'b1;
                cnt[g]  = 3;
                pidx[g] = grp_idx[g*4 +: 4];
            end
        end
        grp_done = dv | inj_done;
        grp_bit  = bv | inj_bit;
        start    = drv_start;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; grp_done = '0; grp_bit = '0;
        repeat (2) @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (grp_start !== 4'b0) begin errors++; $display("FAIL reset_grp_start: got %b expected 0000", grp_start); end
        checks++; if (grp_idx !== 16'h0) begin errors++; $display("FAIL reset_grp_idx: got %h expected 0000", grp_idx); end
        checks++; if (hidden_data !== 10'b0) begin errors++; $display("FAIL reset_hidden: got %b expected 0", hidden_data); end
        reset = 1'b0;
        step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_nominal_pass();
        int dcnt = 0;
        int dat  = -1;
        drv_start = 1'b1; step(); drv_start = 1'b0;
        for (int rel = 1; rel <= 24; rel++) begin
            step();
            if (done === 1'b1) begin dcnt++; dat = rel; end
            if (rel == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nom_busy: got %b expected 1", busy); end
                checks++; if (grp_start !== 4'b1111) begin errors++; $display("FAIL nom_round1_start: got %b expected 1111", grp_start); end
                checks++; if (grp_idx !== 16'h3210) begin errors++; $display("FAIL nom_round1_idx: got %h expected 3210", grp_idx); end
            end
            if (rel == 4) begin
                checks++; if (grp_start !== 4'b0000) begin errors++; $display("FAIL nom_no_same_cycle_redispatch: got %b expected 0000", grp_start); end
            end
            if (rel == 5) begin
                checks++; if (grp_start !== 4'b1111) begin errors++; $display("FAIL nom_round2_start: got %b expected 1111", grp_start); end
                checks++; if (grp_idx !== 16'h7654) begin errors++; $display("FAIL nom_round2_idx: got %h expected 7654", grp_idx); end
                checks++; if (hidden_data[3:0] !== 4'b1010) begin errors++; $display("FAIL nom_simul_capture: got %b expected 1010", hidden_data[3:0]); end
            end
            if (rel == 9) begin
                checks++; if (grp_start !== 4'b0011) begin errors++; $display("FAIL nom_round3_start: got %b expected 0011", grp_start); end
                checks++; if (grp_idx !== 16'h7698) begin errors++; $display("FAIL nom_round3_idx: got %h expected 7698", grp_idx); end
            end
            if (rel == 15) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nom_busy_after_finish: got %b expected 0", busy); end
            end
        end
        checks++; if (dcnt != 1) begin errors++; $display("FAIL nom_done_count: got %0d expected 1", dcnt); end
        checks++; if (dat != 14) begin errors++; $display("FAIL nom_done_cycle: got %0d expected 14", dat); end
        checks++; if (hidden_data !== 10'b1010101010) begin errors++; $display("FAIL nom_hidden: got %b expected 1010101010", hidden_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL nom_err: got %b expected 0", err); end
    endtask

    task automatic test_start_in_wait_and_stray_done();
        int dcnt = 0;
        int dat  = -1;
        drv_start = 1'b1; step(); drv_start = 1'b0;
        for (int rel = 1; rel <= 24; rel++) begin
            drv_start = (rel == 10);
            inj_done  = (rel == 11) ? 4'b0100 : 4'b0000;
            inj_bit   = (rel == 11) ? 4'b0100 : 4'b0000;
            step();
            if (done === 1'b1) begin dcnt++; dat = rel; end
            if (rel == 12) begin
                checks++; if (err !== 1'b1) begin errors++; $display("FAIL stray_err: got %b expected 1", err); end
            end
        end
        drv_start = 1'b0; inj_done = '0; inj_bit = '0;
        checks++; if (dat != 14) begin errors++; $display("FAIL wait_start_done_cycle: got %0d expected 14", dat); end
        checks++; if (dcnt != 1) begin errors++; $display("FAIL wait_start_done_count: got %0d expected 1", dcnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wait_start_busy: got %b expected 0", busy); end
        checks++; if (hidden_data !== 10'b1010101010) begin errors++; $display("FAIL stray_hidden: got %b expected 1010101010", hidden_data); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
    endtask

    task automatic test_reset_mid_pass();
        int dcnt = 0;
        int dat  = -1;
        drv_start = 1'b1; step(); drv_start = 1'b0;
        step(); step();
        reset = 1'b1;
        pend  = '0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (grp_start !== 4'b0) begin errors++; $display("FAIL midrst_grp_start: got %b expected 0000", grp_start); end
        checks++; if (grp_idx !== 16'h0) begin errors++; $display("FAIL midrst_grp_idx: got %h expected 0000", grp_idx); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b expected 0", err); end
        for (int i = 0; i < 3; i++) begin step(); if (done === 1'b1) dcnt++; end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin step(); if (done === 1'b1) dcnt++; end
        checks++; if (dcnt != 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", dcnt); end
        checks++; if (hidden_data !== 10'b0) begin errors++; $display("FAIL midrst_hidden: got %b expected 0", hidden_data); end
        drv_start = 1'b1; step(); drv_start = 1'b0;
        for (int rel = 1; rel <= 24; rel++) begin
            step();
            if (done === 1'b1) begin dcnt++; dat = rel; end
        end
        checks++; if (dat != 14) begin errors++; $display("FAIL fresh_done_cycle: got %0d expected 14", dat); end
        checks++; if (dcnt != 1) begin errors++; $display("FAIL fresh_done_count: got %0d expected 1", dcnt); end
        checks++; if (hidden_data !== 10'b1010101010) begin errors++; $display("FAIL fresh_hidden: got %b expected 1010101010", hidden_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL fresh_err: got %b expected 0", err); end
    endtask

`ifdef RBM_SCHED_TIMEOUT_EN
    task automatic test_watchdog();
        int dcnt = 0;
        int dat  = -1;
        resp_en = 4'b1101;
        drv_start = 1'b1; step(); drv_start = 1'b0;
        for (int rel = 1; rel <= 40; rel++) begin
            step();
            if (done === 1'b1) begin dcnt++; dat = rel; end
            if (rel == 5) begin
                checks++; if (grp_start !== 4'b1101) begin errors++; $display("FAIL wd_round2_start: got %b expected 1101", grp_start); end
                checks++; if (grp_idx !== 16'h6514) begin errors++; $display("FAIL wd_round2_idx: got %h expected 6514", grp_idx); end
            end
        end
        resp_en = 4'b1111;
        checks++; if (dat != 28) begin errors++; $display("FAIL wd_done_cycle: got %0d expected 28", dat); end
        checks++; if (dcnt != 1) begin errors++; $display("FAIL wd_done_count: got %0d expected 1", dcnt); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd_err: got %b expected 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_busy: got %b expected 0", busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal_pass();
        test_start_in_wait_and_stray_done();
        test_reset_mid_pass();
`ifdef RBM_SCHED_TIMEOUT_EN
        test_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL time_limit: simulation did not complete within 100000 time units");
        $fatal(1, "time limit");
    end

endmodule
